de_emphasis: RTL and testbench

- Inverse of the MFCC front-end pre-emphasis stage: first-order IIR de-emphasis, y[n] = sat(x[n] + ALPHA*y[n-1]), samples in signed Q1.15.
- Used on the reconstruction/monitor path and for round-trip checks of the pre-emphasis stage.
- Valid/ready handshake on both sides; per-frame state clear; saturating arithmetic.

---
 rtl/de_emphasis.sv | 117 +++++++++++
 tb/tb_de_emphasis.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/de_emphasis.sv
// First-order IIR de-emphasis y[n] = sat(x[n] + ALPHA*y[n-1]) on signed Q1.15 samples.
// Optional saturation-event counter enabled by defining DEEMPH_OVF_CNT_EN.
module de_emphasis #(
  parameter int          SAMPLE_WIDTH = 16,
  parameter logic [15:0] ALPHA        = 16'd31785
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_WIDTH-1:0] x_in,
  input  logic                    frame_start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SAMPLE_WIDTH-1:0] y_out,
  output logic                    sat_flag,
  output logic [15:0]             ovf_count
);

  localparam int PW = SAMPLE_WIDTH + 17;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] ADD  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic signed [SAMPLE_WIDTH+1:0] SUM_MAX = {3'b000, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [SAMPLE_WIDTH+1:0] SUM_MIN = {3'b111, {(SAMPLE_WIDTH-1){1'b0}}};

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its data stable until that edge, ready never depends on in_valid.
  logic [1:0]                     state;
  logic signed [SAMPLE_WIDTH-1:0] x_reg;
  logic signed [SAMPLE_WIDTH-1:0] y_prev;
  logic signed [PW-1:0]           prod;
  logic signed [SAMPLE_WIDTH:0]   fb;
  logic signed [SAMPLE_WIDTH+1:0] sum;
  logic signed [SAMPLE_WIDTH-1:0] y_sat;
  logic                           clip;
  logic                           accept;
  logic                           unused_prod_bits;

  assign in_ready = (state == IDLE) || (state == HOLD && out_ready);
  assign accept   = in_valid && in_ready;

  // Taking bits [SW+15:15] of the signed product is an arithmetic shift by 15 (floor).
  assign fb               = prod[SAMPLE_WIDTH+15:15];
  assign unused_prod_bits = ^{prod[PW-1:SAMPLE_WIDTH+16], prod[14:0]};

  always_comb begin
    sum   = {{2{x_reg[SAMPLE_WIDTH-1]}}, x_reg} + {fb[SAMPLE_WIDTH], fb};
    clip  = 1'b0;
    y_sat = sum[SAMPLE_WIDTH-1:0];
    if (sum > SUM_MAX) begin
      clip  = 1'b1;
      y_sat = SUM_MAX[SAMPLE_WIDTH-1:0];
    end else if (sum < SUM_MIN) begin
      clip  = 1'b1;
      y_sat = SUM_MIN[SAMPLE_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_reg     <= '0;
      y_prev    <= '0;
      prod      <= '0;
      y_out     <= '0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            x_reg     <= x_in;
            if (frame_start) y_prev <= '0;
            out_valid <= 1'b0;
            state     <= MUL;
          end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        MUL: begin
          prod  <= y_prev * $signed({1'b0, ALPHA});
          state <= ADD;
        end
        default: begin
          // Feedback history takes the clamped value, never the raw sum.
          y_out     <= y_sat;
          y_prev    <= y_sat;
          sat_flag  <= clip;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
      endcase
    end
  end

`ifdef DEEMPH_OVF_CNT_EN
  logic [15:0] ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else if (state == ADD && clip && ovf_q != 16'hFFFF) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_de_emphasis.sv
// Self-checking bench for de_emphasis: directed cases plus randomized traffic with random
// backpressure, checked against an integer-arithmetic reference model and scoreboard queue.
module tb_de_emphasis;

  localparam int ALPHA = 31785;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in;
  logic        frame_start;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y_out;
  logic        sat_flag;
  logic [15:0] ovf_count;

  de_emphasis #(.SAMPLE_WIDTH(16), .ALPHA(16'd31785)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .frame_start(frame_start),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .sat_flag(sat_flag),
    .ovf_count(ovf_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // scoreboard: {sat, y}
  logic [16:0] exp_q[$];

  // reference model state
  int m_yprev = 0;
  int m_ovf   = 0;

  // driver knobs and sampled outputs
  int          rdy_force = 1;
  bit          pend      = 0;
  logic [15:0] pend_x    = '0;
  bit          pend_fs   = 0;
  logic        s_ov, s_ir, s_sat;
  logic [15:0] s_y;
  int          last_y;
  int          last_sat;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_push(input int x, input bit fs);
    longint p, fb, s;
    bit     sat;
    if (fs) m_yprev = 0;
    p  = longint'(m_yprev) * ALPHA;
    fb = (p >= 0) ? p / 32768 : -((-p + 32767) / 32768);
    s  = x + fb;
    sat = 1'b0;
    if (s > 32767) begin s = 32767; sat = 1'b1; end
    else if (s < -32768) begin s = -32768; sat = 1'b1; end
    m_yprev = int'(s);
`ifdef DEEMPH_OVF_CNT_EN
    if (sat && m_ovf < 65535) m_ovf++;
`endif
    exp_q.push_back({sat, s[15:0]});
  endtask

  // one cycle: drive after the falling edge, sample 1 time unit later
  task automatic step();
    logic [16:0] e;
    @(negedge clk);
    if (rdy_force == 1) out_ready = 1'b1;
    else if (rdy_force == 0) out_ready = 1'b0;
    else out_ready = 1'($urandom_range(0, 1));
    in_valid = pend;
    if (pend) begin
      x_in        = pend_x;
      frame_start = pend_fs;
    end else begin
      x_in        = 16'($urandom);
      frame_start = 1'($urandom_range(0, 1));
    end
    #1;
    s_ov = out_valid; s_ir = in_ready; s_y = y_out; s_sat = sat_flag;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("y_out", int'($signed(y_out)), int'($signed(e[15:0])));
        check("sat_flag", int'(sat_flag), int'(e[16]));
      end
      last_y   = int'($signed(y_out));
      last_sat = int'(sat_flag);
    end
    if (in_valid && in_ready) begin
      model_push(int'($signed(x_in)), frame_start);
      pend = 0;
    end
  endtask

  task automatic send(input int x, input bit fs);
    int n;
    pend = 1; pend_x = x[15:0]; pend_fs = fs;
    n = 0;
    while (pend && n < 50) begin step(); n++; end
    if (pend) begin
      check("accept_timeout", 0, 1);
      pend = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin step(); n++; end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic directed(input string tag, input int x, input bit fs, input int ey, input int es);
    send(x, fs);
    drain();
    check({tag, "_y"}, last_y, ey);
    check({tag, "_sat"}, last_sat, es);
  endtask

  initial begin
    int y0, sat0, n, ovf_exp;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_y_out", int'(y_out), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_ovf_count", int'(ovf_count), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    rdy_force = 1;
    directed("imp0", 16384, 1, 16384, 0);
    directed("imp1", 0, 0, 15892, 0);
    directed("imp2", 0, 0, 15415, 0);
    directed("frame_clr", 0, 1, 0, 0);

    directed("psat0", 32767, 1, 32767, 0);
    directed("psat1", 32767, 0, 32767, 1);
`ifdef DEEMPH_OVF_CNT_EN
    ovf_exp = 1;
`else
    ovf_exp = 0;
`endif
    check("psat_ovf", int'(ovf_count), ovf_exp);

    directed("nfl0", -1, 1, -1, 0);
    for (int i = 1; i < 4; i++) directed($sformatf("nfl%0d", i), 0, 0, -1, 0);
    directed("nsat0", -32768, 1, -32768, 0);
    directed("nsat1", -32768, 0, -32768, 1);

    // backpressure: hold the first output for 5 cycles
    rdy_force = 0;
    send(1000, 1);
    n = 0;
    while (!s_ov && n < 10) begin step(); n++; end
    check("bp_valid_seen", int'(s_ov), 1);
    y0 = int'(s_y); sat0 = int'(s_sat);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_y_stable", int'(s_y), y0);
      check("bp_sat_stable", int'(s_sat), sat0);
      check("bp_valid_stable", int'(s_ov), 1);
      check("bp_in_ready", int'(s_ir), 0);
    end
    rdy_force = 1;
    send(-2000, 0);
    check("bp_same_cycle_accept", int'(s_ir), 1);
    step(); check("bp_lat1", int'(s_ov), 0);
    step(); check("bp_lat2", int'(s_ov), 0);
    step(); check("bp_lat3", int'(s_ov), 1);
    drain();

    // reset while the sample sits in MUL
    send(1234, 0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_y_out", int'(y_out), 0);
    check("mid_rst_ovf", int'(ovf_count), 0);
    exp_q.delete(); m_yprev = 0; m_ovf = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    directed("post_rst", 100, 0, 100, 0);
    repeat (4) step();
    check("post_rst_no_extra", exp_q.size(), 0);

    // randomized traffic with random backpressure and gaps
    rdy_force = -1;
    for (int i = 0; i < 300; i++) begin
      int x;
      case ($urandom_range(0, 3))
        0: x = 32767;
        1: x = -32768;
        default: x = int'($signed(16'($urandom)));
      endcase
      send(x, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) step();
    end
    drain();
    check("ovf_end", int'(ovf_count), m_ovf);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
